seq_detect_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector. Generalises the fixed 4-bit "0111" Moore detector to any pattern of 1..MAX_LEN bits.
- Adds selectable overlapping/non-overlapping matching, a bit-valid qualifier and a saturating match counter.
- Sits on a serial data stream and raises a registered one-cycle flag after each pattern occurrence.

---
 rtl/seq_detect_prog.sv | 105 ++++++++++
 tb/tb_seq_detect_prog.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control and saturating match counter.
// DOUT rises the cycle after the completing bit is accepted; configuration writes take priority over data.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               DIN_VALID,
  input  logic               DIN,
  input  logic               CFG_WE,
  input  logic [MAX_LEN-1:0] CFG_PATTERN,
  input  logic [LEN_W-1:0]   CFG_LEN,
  input  logic               CFG_OVERLAP,
  input  logic               CNT_CLR,
  output logic               DOUT,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               ARMED,
  output logic               CFG_ERR
);

  localparam logic [1:0] UNCFG = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] ARMD  = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt, hist_sh, pat, mask;
  logic [LEN_W-1:0]   len, fill, fill_nxt, fill_inc;
  logic               ovl;
  logic               cfg_ok, accept, full, hit, match;
  logic [CNT_W-1:0]   cnt_nxt;

  always_comb begin
    cfg_ok     = (CFG_LEN != '0) && (CFG_LEN <= LEN_W'(MAX_LEN));
    accept     = DIN_VALID && !CFG_WE && (state != UNCFG);
    hist_sh    = hist << 1;
    hist_sh[0] = DIN;
    mask       = ~({MAX_LEN{1'b1}} << len);
    hit        = (((hist_sh ^ pat) & mask) == '0);
    fill_inc   = fill + LEN_W'(1);
    // A compare is only meaningful once LEN fresh bits are in the history.
    full       = (state == ARMD) || (fill_inc == len);
    match      = accept && full && hit;

    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    if (CFG_WE) begin
      if (cfg_ok) begin
        hist_nxt  = '0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end
    end else if (accept) begin
      hist_nxt = hist_sh;
      if (match && !ovl) begin
        fill_nxt  = '0;
        state_nxt = FILL;
      end else if (full) begin
        fill_nxt  = len;
        state_nxt = ARMD;
      end else begin
        fill_nxt = fill_inc;
      end
    end

    cnt_nxt = MATCH_CNT;
    if (match) begin
      if (CNT_CLR)               cnt_nxt = CNT_W'(1);
      else if (~&MATCH_CNT)      cnt_nxt = MATCH_CNT + CNT_W'(1);
    end else if (CNT_CLR) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= UNCFG;
      hist      <= '0;
      fill      <= '0;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      DOUT      <= 1'b0;
      MATCH_CNT <= '0;
      CFG_ERR   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      DOUT      <= match;
      MATCH_CNT <= cnt_nxt;
      CFG_ERR   <= CFG_WE && !cfg_ok;
      if (CFG_WE && cfg_ok) begin
        pat <= CFG_PATTERN;
        len <= CFG_LEN;
        ovl <= CFG_OVERLAP;
      end
    end
  end

  assign ARMED = (state == ARMD);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised and directed stimulus for seq_detect_prog, checked against a bit-queue reference model.
module tb_seq_detect_prog;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic               DIN_VALID = 1'b0;
  logic               DIN = 1'b0;
  logic               CFG_WE = 1'b0;
  logic [MAX_LEN-1:0] CFG_PATTERN = '0;
  logic [LEN_W-1:0]   CFG_LEN = '0;
  logic               CFG_OVERLAP = 1'b0;
  logic               CNT_CLR = 1'b0;
  logic               DOUT;
  logic [CNT_W-1:0]   MATCH_CNT;
  logic               ARMED;
  logic               CFG_ERR;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DIN_VALID(DIN_VALID), .DIN(DIN),
    .CFG_WE(CFG_WE), .CFG_PATTERN(CFG_PATTERN), .CFG_LEN(CFG_LEN),
    .CFG_OVERLAP(CFG_OVERLAP), .CNT_CLR(CNT_CLR), .DOUT(DOUT),
    .MATCH_CNT(MATCH_CNT), .ARMED(ARMED), .CFG_ERR(CFG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             dout;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: configured flag, pattern, and the bits received since the last restart.
  bit               m_cfg = 0;
  logic [MAX_LEN-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ovl = 0;
  int               m_fresh = 0;
  int               m_cnt = 0;
  bit               m_bits[$];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic cycle(input bit v, input bit d, input bit we, input logic [MAX_LEN-1:0] p,
                       input logic [LEN_W-1:0] l, input bit o, input bit clr);
    exp_t e;
    bit   match;
    match = 0;
    @(negedge CLK);
    DIN_VALID = v; DIN = d; CFG_WE = we; CFG_PATTERN = p; CFG_LEN = l;
    CFG_OVERLAP = o; CNT_CLR = clr;
    e.err = we && (l == 0 || int'(l) > MAX_LEN);
    if (we) begin
      if (!e.err) begin
        m_cfg = 1; m_pat = p; m_len = int'(l); m_ovl = o; m_fresh = 0;
        m_bits.delete();
      end
    end else if (v && m_cfg) begin
      m_bits.push_back(d);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      m_fresh++;
      if (m_fresh >= m_len) begin
        match = 1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - m_len + i] != m_pat[m_len - 1 - i]) match = 0;
      end
      if (match && !m_ovl) m_fresh = 0;
    end
    if (match) m_cnt = clr ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
    else if (clr) m_cnt = 0;
    e.dout  = match;
    e.cnt   = CNT_W'(m_cnt);
    e.armed = m_cfg && (m_fresh >= m_len);
    exp_q.push_back(e);
  endtask

  task automatic bitin(input bit d);
    cycle(1, d, 0, '0, '0, 0, 0);
  endtask

  task automatic idle(input bit clr);
    cycle(0, 0, 0, '0, '0, 0, clr);
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
    cycle(0, 0, 1, p, l, o, 0);
  endtask

  // Waits for the edge that consumes the last driven cycle, then checks fixed expectations.
  task automatic snap(input string name, input int want_cnt, input int want_armed);
    @(posedge CLK);
    #3;
    check({name, "_cnt"}, int'(MATCH_CNT), want_cnt);
    check({name, "_armed"}, int'(ARMED), want_armed);
  endtask

  task automatic stream(input int n, input logic [15:0] bits);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) bitin(b[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", int'(DOUT), int'(e.dout));
        check("match_cnt", int'(MATCH_CNT), int'(e.cnt));
        check("armed", int'(ARMED), int'(e.armed));
        check("cfg_err", int'(CFG_ERR), int'(e.err));
      end
    end
  end

  initial begin : driver
    #2;
    check("rst_dout", int'(DOUT), 0);
    check("rst_cnt", int'(MATCH_CNT), 0);
    check("rst_armed", int'(ARMED), 0);
    check("rst_err", int'(CFG_ERR), 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Bits before any configuration are ignored.
    stream(4, 16'b0111);

    cfg(8'b0111, 4, 1);
    stream(9, 16'b011110111);
    snap("tp_0111", 2, 1);

    cfg(8'b101, 3, 1);
    idle(1);
    stream(5, 16'b10101);
    snap("tp_101_ovl", 2, 1);

    cfg(8'b101, 3, 0);
    idle(1);
    stream(5, 16'b10101);
    snap("tp_101_novl", 1, 0);

    cfg(8'b0111, 4, 1);
    idle(1);
    bitin(0); bitin(1); idle(0); idle(0); idle(0); bitin(1); bitin(1);
    snap("tp_gap", 1, 1);

    idle(1);
    cfg(8'b0, 0, 0);
    cfg(8'b0, 9, 0);
    stream(4, 16'b0111);
    snap("tp_badcfg", 1, 1);

    // Legal write with a coincident bit: the bit is dropped and fill restarts.
    cycle(1, 0, 1, 8'b0111, 4, 1, 0);
    stream(3, 16'b111);
    stream(4, 16'b0111);
    snap("tp_cfg_drop", 2, 1);

    cfg(8'b1, 1, 1);
    idle(1);
    stream(6, 16'b111111);
    snap("tp_sat", 3, 1);
    cycle(1, 1, 0, '0, '0, 0, 1);
    snap("tp_clr_match", 1, 1);

    cfg(8'b0111, 4, 1);
    stream(3, 16'b011);
    @(posedge CLK);
    #3;
    DIN_VALID = 0; CFG_WE = 0; CNT_CLR = 0;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_dout", int'(DOUT), 0);
    check("mid_rst_cnt", int'(MATCH_CNT), 0);
    check("mid_rst_armed", int'(ARMED), 0);
    check("mid_rst_err", int'(CFG_ERR), 0);
    m_cfg = 0; m_cnt = 0; m_fresh = 0; m_len = 0; m_bits.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    stream(5, 16'b10111);
    snap("tp_post_rst", 0, 0);

    for (int n = 0; n < 2000; n++) begin
      logic [MAX_LEN-1:0] p;
      logic [LEN_W-1:0]   l;
      p = MAX_LEN'($urandom);
      l = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(1, 4));
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
            p, l, 1'($urandom), $urandom_range(0, 29) == 0);
    end

    idle(0);
    idle(0);
    repeat (3) @(posedge CLK);
    #3;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
